// File: rtl/debug_wb_initiator.sv
// debug_wb_initiator: Wishbone B3 classic single-transfer initiator for the
// SoC debug path. It takes one read/write command from the debug command
// channel and runs it as one Wishbone cycle. The cycle ends on err, ack or rty.
// Retries are bounded and each attempt has a timeout. Status and read data
// come back on a response channel.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-low reset
//   cmd_*              command channel (valid/ready), we/addr/data/sel
//   rsp_*              response channel (valid/ready), read data + status
//                      status: 00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED
//   m_*_o / m_*_i      Wishbone initiator outputs / target responses
// All outputs are registered.
module debug_wb_initiator #(
  parameter int unsigned dw        = 32,
  parameter int unsigned aw        = 16,
  parameter int unsigned sw        = dw / 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_addr_i,
  input  logic [dw-1:0] cmd_data_i,
  input  logic [sw-1:0] cmd_sel_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [dw-1:0] rsp_data_o,
  output logic [1:0]    rsp_status_o,
  output logic [dw-1:0] m_data_o,
  output logic [aw-1:0] m_addr_o,
  output logic [sw-1:0] m_sel_o,
  output logic          m_we_o,
  output logic          m_cyc_o,
  output logic          m_stb_o,
  input  logic [dw-1:0] m_data_i,
  input  logic          m_ack_i,
  input  logic          m_err_i,
  input  logic          m_rty_i
);

  localparam int unsigned TW = 8;
  localparam int unsigned RW = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUS     = 2'd1;
  localparam logic [1:0] BACKOFF = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rty_q, rty_d;

  logic          cmd_ready_d;
  logic          rsp_valid_d;
  logic [dw-1:0] rsp_data_d;
  logic [1:0]    rsp_status_d;
  logic [dw-1:0] m_data_d;
  logic [aw-1:0] m_addr_d;
  logic [sw-1:0] m_sel_d;
  logic          m_we_d;
  logic          m_cyc_d;
  logic          m_stb_d;

  // Next-state and next-output logic; outputs are registered copies derived from state_d.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    rty_d        = rty_q;
    rsp_data_d   = rsp_data_o;
    rsp_status_d = rsp_status_o;
    m_data_d     = m_data_o;
    m_addr_d     = m_addr_o;
    m_sel_d      = m_sel_o;
    m_we_d       = m_we_o;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          m_we_d   = cmd_we_i;
          m_addr_d = cmd_addr_i;
          m_data_d = cmd_data_i;
          m_sel_d  = cmd_sel_i;
          tmo_d    = '0;
          rty_d    = '0;
          state_d  = BUS;
        end
      end
      BUS: begin
        // Terminations are only sampled here, so they are ignored while m_stb_o is low.
        if (m_err_i) begin
          rsp_status_d = ST_ERR;
          rsp_data_d   = '0;
          state_d      = RESP;
        end else if (m_ack_i) begin
          rsp_status_d = ST_OK;
          rsp_data_d   = m_we_o ? '0 : m_data_i;
          state_d      = RESP;
        end else if (m_rty_i) begin
          if (rty_q == RW'(MAX_RETRY)) begin
            rsp_status_d = ST_RETRY;
            rsp_data_d   = '0;
            state_d      = RESP;
          end else begin
            rty_d   = rty_q + RW'(1);
            state_d = BACKOFF;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th strobe cycle with no termination.
          rsp_status_d = ST_TIMEOUT;
          rsp_data_d   = '0;
          state_d      = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      BACKOFF: begin
        tmo_d   = '0;
        state_d = BUS;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    m_cyc_d     = (state_d == BUS);
    m_stb_d     = (state_d == BUS);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      rty_q        <= '0;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_status_o <= ST_OK;
      m_data_o     <= '0;
      m_addr_o     <= '0;
      m_sel_o      <= '0;
      m_we_o       <= 1'b0;
      m_cyc_o      <= 1'b0;
      m_stb_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      rty_q        <= rty_d;
      cmd_ready_o  <= cmd_ready_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_data_o   <= rsp_data_d;
      rsp_status_o <= rsp_status_d;
      m_data_o     <= m_data_d;
      m_addr_o     <= m_addr_d;
      m_sel_o      <= m_sel_d;
      m_we_o       <= m_we_d;
      m_cyc_o      <= m_cyc_d;
      m_stb_o      <= m_stb_d;
    end
  end

endmodule

// File: tb/tb_debug_wb_initiator.sv
// Testbench for debug_wb_initiator. The target is driven from a per-command
// script of attempts, where each attempt is a number of wait states and a
// termination kind. Expected status, data, strobe cycles, backoff gaps and
// latency come from a reference model evaluated over that script.
module tb_debug_wb_initiator;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 16;
  localparam int unsigned SW   = 4;
  localparam int unsigned TMO  = 10;
  localparam int unsigned MAXR = 3;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_ERRACK = 2;
  localparam int K_RTY    = 3;
  localparam int K_NONE   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic [DW-1:0] m_data_o;
  logic [AW-1:0] m_addr_o;
  logic [SW-1:0] m_sel_o;
  logic          m_we_o;
  logic          m_cyc_o;
  logic          m_stb_o;
  logic [DW-1:0] m_data_i;
  logic          m_ack_i;
  logic          m_err_i;
  logic          m_rty_i;

  int checks = 0;
  int errors = 0;
  int unsigned cyc_cnt = 0;

  // Target script for the current command.
  int att_n;
  int att_w [8];
  int att_k [8];

  debug_wb_initiator #(
    .dw(DW), .aw(AW), .sw(SW), .TIMEOUT(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_addr_i   (cmd_addr),
    .cmd_data_i   (cmd_data),
    .cmd_sel_i    (cmd_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_status_o (rsp_status),
    .m_data_o     (m_data_o),
    .m_addr_o     (m_addr_o),
    .m_sel_o      (m_sel_o),
    .m_we_o       (m_we_o),
    .m_cyc_o      (m_cyc_o),
    .m_stb_o      (m_stb_o),
    .m_data_i     (m_data_i),
    .m_ack_i      (m_ack_i),
    .m_err_i      (m_err_i),
    .m_rty_i      (m_rty_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference outcome of the current script: walk the attempts in order.
  task automatic model(input logic we, input logic [DW-1:0] rdata,
                       output logic [1:0] st, output logic [DW-1:0] d,
                       output int s, output int g);
    int retries;
    retries = 0;
    s = 0;
    g = 0;
    d = '0;
    st = 2'b10;
    for (int i = 0; i < att_n; i++) begin
      if (att_k[i] == K_NONE || att_w[i] + 1 > int'(TMO)) begin
        s += int'(TMO);
        st = 2'b10;
        return;
      end
      s += att_w[i] + 1;
      if (att_k[i] == K_ERR || att_k[i] == K_ERRACK) begin
        st = 2'b01;
        return;
      end
      if (att_k[i] == K_ACK) begin
        st = 2'b00;
        d = we ? '0 : rdata;
        return;
      end
      if (retries == int'(MAXR)) begin
        st = 2'b11;
        return;
      end
      retries++;
      g++;
    end
    // The script ran out: the target stays silent and the attempt times out.
    s += int'(TMO);
    st = 2'b10;
  endtask

  // Called at a negedge with the DUT idle. Runs one command to completion.
  task automatic run_cmd(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] sel,
                         input logic [DW-1:0] rdata, input int hold,
                         output int unsigned hs_cyc);
    logic [1:0]    e_st;
    logic [DW-1:0] e_d;
    int e_s, e_g;
    int s, g, n, stb_cnt, idx;
    s = 0; g = 0; n = 1; stb_cnt = 0; idx = 0;
    model(we, rdata, e_st, e_d, e_s, e_g);

    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_sel   = sel;
    m_data_i  = rdata;
    hs_cyc    = cyc_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_data  = $urandom;
    cmd_sel   = SW'($urandom);

    while (!rsp_valid && n < 400) begin
      if (m_stb_o) begin
        s++;
        stb_cnt++;
        chk("bus_addr", 64'(m_addr_o), 64'(addr));
        chk("bus_we",   64'(m_we_o),   64'(we));
        chk("bus_data", 64'(m_data_o), 64'(data));
        chk("bus_sel",  64'(m_sel_o),  64'(sel));
        chk("bus_cyc",  64'(m_cyc_o),  64'(1));
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_rty_i = 1'b0;
        if (idx < att_n && att_k[idx] != K_NONE && stb_cnt == att_w[idx] + 1) begin
          case (att_k[idx])
            K_ACK:    m_ack_i = 1'b1;
            K_ERR:    m_err_i = 1'b1;
            K_ERRACK: begin m_err_i = 1'b1; m_ack_i = 1'b1; end
            default:  m_rty_i = 1'b1;
          endcase
          idx++;
        end
      end else begin
        g++;
        stb_cnt = 0;
        // Terminations while the strobe is low must be ignored.
        m_ack_i = 1'($urandom);
        m_err_i = 1'($urandom);
        m_rty_i = 1'($urandom);
        chk("gap_cyc", 64'(m_cyc_o), 64'(0));
      end
      @(negedge clk);
      n++;
    end
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_rty_i = 1'b0;

    chk("rsp_valid",   64'(rsp_valid),  64'(1));
    chk("rsp_status",  64'(rsp_status), 64'(e_st));
    chk("rsp_data",    64'(rsp_data),   64'(e_d));
    chk("stb_cycles",  64'(s),          64'(e_s));
    chk("backoffs",    64'(g),          64'(e_g));
    chk("latency",     64'(n),          64'(1 + e_s + e_g));
    chk("resp_cyc",    64'(m_cyc_o),    64'(0));
    chk("resp_ready",  64'(cmd_ready),  64'(0));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid",  64'(rsp_valid),  64'(1));
      chk("hold_status", 64'(rsp_status), 64'(e_st));
      chk("hold_data",   64'(rsp_data),   64'(e_d));
      chk("hold_ready",  64'(cmd_ready),  64'(0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_clear", 64'(rsp_valid), 64'(0));
  endtask

  task automatic set1(input int k, input int w);
    att_n = 1;
    att_k[0] = k;
    att_w[0] = w;
  endtask

  initial begin
    int unsigned hs0, hs1, hs_tmp;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    m_data_i  = '0;
    m_ack_i   = 1'b0;
    m_err_i   = 1'b0;
    m_rty_i   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready),  64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid),  64'(0));
    chk("rst_rsp_data",  64'(rsp_data),   64'(0));
    chk("rst_rsp_stat",  64'(rsp_status), 64'(0));
    chk("rst_cyc_stb",   64'({m_cyc_o, m_stb_o, m_we_o}), 64'(0));
    chk("rst_bus",       64'({m_addr_o, m_sel_o}), 64'(0));
    chk("rst_bus_data",  64'(m_data_o),   64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(cmd_ready), 64'(1));

    // Zero-wait writes back to back: one command per 3 cycles.
    set1(K_ACK, 0);
    run_cmd(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 32'h5555AAAA, 0, hs0);
    set1(K_ACK, 0);
    run_cmd(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 32'h5555AAAA, 0, hs1);
    chk("throughput", 64'(hs1 - hs0), 64'(3));

    // Read with 4 wait states.
    set1(K_ACK, 4);
    run_cmd(1'b0, 16'h1234, 32'h0, 4'hF, 32'hCAFEF00D, 0, hs_tmp);

    // rty, rty, ack.
    att_n = 3;
    att_k[0] = K_RTY; att_w[0] = 0;
    att_k[1] = K_RTY; att_w[1] = 0;
    att_k[2] = K_ACK; att_w[2] = 0;
    run_cmd(1'b0, 16'h0100, 32'h0, 4'h3, 32'h01020304, 0, hs_tmp);

    // Four rty with MAX_RETRY = 3: retries exhausted.
    att_n = 4;
    for (int i = 0; i < 4; i++) begin att_k[i] = K_RTY; att_w[i] = 1; end
    run_cmd(1'b1, 16'h0200, 32'h11223344, 4'hC, 32'h0, 0, hs_tmp);

    // Silent target: timeout after TMO strobe cycles.
    set1(K_NONE, 0);
    run_cmd(1'b0, 16'h0300, 32'h0, 4'hF, 32'hFFFFFFFF, 0, hs_tmp);

    // Termination on the last strobe cycle before the timeout.
    set1(K_ACK, int'(TMO) - 1);
    run_cmd(1'b0, 16'h0304, 32'h0, 4'hF, 32'h0BADCAFE, 0, hs_tmp);

    // err and ack together, with the response held for 5 cycles.
    set1(K_ERRACK, 2);
    run_cmd(1'b0, 16'h0400, 32'h0, 4'h1, 32'h12345678, 5, hs_tmp);

    // Randomized commands.
    for (int c = 0; c < 40; c++) begin
      att_n = int'($urandom_range(1, 6));
      for (int i = 0; i < att_n; i++) begin
        att_k[i] = (i < att_n - 1) ? K_RTY : int'($urandom_range(0, 4));
        att_w[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 12))
                                               : int'($urandom_range(0, 4));
      end
      run_cmd(1'($urandom), AW'($urandom), $urandom, SW'($urandom), $urandom,
              int'($urandom_range(0, 3)), hs_tmp);
    end

    // Reset in the middle of a bus cycle: no response afterwards.
    set1(K_NONE, 0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 16'h0500;
    cmd_data  = 32'hA5A5A5A5;
    cmd_sel   = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_cyc", 64'(m_cyc_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc",   64'(m_cyc_o),   64'(0));
    chk("rst_async_stb",   64'(m_stb_o),   64'(0));
    chk("rst_async_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 64'({rsp_valid, m_cyc_o}), 64'(0));
    end
    chk("rst_idle_ready", 64'(cmd_ready), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_wb_initiator.md
# debug_wb_initiator

Wishbone B3 classic single-transfer initiator for the SoC debug path. It accepts one read or write command at a time from the debug command channel and runs it as a Wishbone cycle on the debug master port of the interconnect. It terminates the cycle on ack, err or rty, with bounded retries and a cycle timeout, and returns data plus status on a response channel.

## Interface
- `dw`, 32, data width
- `aw`, 16, address width
- `sw`, 4, byte-select width (dw/8)
- `TIMEOUT`, 255, maximum cycles `m_stb_o` stays high without termination; range 1..255
- `MAX_RETRY`, 3, `m_rty_i` terminations tolerated before giving up; range 0..15

- `clk_i` in 1: single clock, all logic on the rising edge
- `rst_i` in 1: asynchronous, active-low reset
- `cmd_valid_i` in 1: command present
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i` and `cmd_ready_o` are both high
- `cmd_we_i` in 1: 1 = write, 0 = read
- `cmd_addr_i` in aw: target address
- `cmd_data_i` in dw: write data
- `cmd_sel_i` in sw: byte selects
- `rsp_valid_o` out 1: response present
- `rsp_ready_i` in 1: response consumed
- `rsp_data_o` out dw: read data; 0 for writes and for failed reads
- `rsp_status_o` out 2: 00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED
- `m_data_o` out dw, `m_addr_o` out aw, `m_sel_o` out sw, `m_we_o` out 1, `m_cyc_o` out 1, `m_stb_o` out 1: Wishbone initiator outputs
- `m_data_i` in dw, `m_ack_i` in 1, `m_err_i` in 1, `m_rty_i` in 1: Wishbone target responses

## Operation
- FSM states: IDLE, BUS, BACKOFF, RESP.
- **IDLE**
  - `cmd_ready_o` = 1.
  - On handshake: latch we, addr, data and sel into the `m_*` output registers; clear the retry and timeout counters; go to BUS.
- **BUS**
  - `m_cyc_o` = `m_stb_o` = 1. Address, data, sel and we are held stable.
  - Sample terminations each cycle with priority err > ack > rty:
    - err: go to RESP, status 01.
    - ack: go to RESP, status 00. For reads, capture `m_data_i` into `rsp_data_o`.
    - rty with retry count == MAX_RETRY: go to RESP, status 11.
    - rty otherwise: increment retry count, go to BACKOFF.
  - If no termination, increment the timeout counter. When the counter reaches TIMEOUT, go to RESP with status 10.
- **BACKOFF**
  - Exactly one cycle with `m_cyc_o` = `m_stb_o` = 0.
  - Clear the timeout counter and return to BUS with the same latched command.
- **RESP**
  - `m_cyc_o` = `m_stb_o` = 0; `rsp_valid_o` = 1.
  - Data and status are held stable until `rsp_ready_i`, then go to IDLE.
  - `cmd_ready_o` = 0 in every state except IDLE.
- Terminations arriving while `m_stb_o` is low are ignored.
- Reset mid-cycle: `m_cyc_o` and `m_stb_o` drop immediately (asynchronous) and the in-flight command is discarded with no response.

## Timing
- Reset values: `cmd_ready_o` = 1; `rsp_valid_o` = 0; `rsp_data_o` = 0; `rsp_status_o` = 00; `m_cyc_o` = `m_stb_o` = `m_we_o` = 0; `m_addr_o`, `m_data_o`, `m_sel_o` = 0; FSM in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Command handshake at edge N gives `m_cyc_o` and `m_stb_o` high in cycle N+1.
- Zero-wait ack in cycle N+1 gives `rsp_valid_o` high and `m_cyc_o` low in cycle N+2.
- Throughput with a zero-wait target and `rsp_ready_i` tied high is one command per 3 cycles: IDLE, BUS, RESP.
- Each rty adds 2 cycles (BUS, BACKOFF) before the next attempt.
- Timeout with no response: strobe is high for exactly TIMEOUT cycles, then `rsp_valid_o` rises in the next cycle.
- Timeout counter is 8 bits and retry counter is 4 bits; neither wraps, because each is bounded by its parameter check.

## Test plan
- Write 0xDEADBEEF to 0x0040 with sel 0xF, target acks in the first cycle:
  - `m_cyc_o` rises 1 cycle after the handshake and `m_stb_o` is high for exactly 1 cycle.
  - Response status 00, data 0, 3 cycles per command.
- Read 0x1234 with ack after 4 wait states and `m_data_i` = 0xCAFEF00D:
  - `rsp_data_o` = 0xCAFEF00D, status 00.
  - `m_addr_o` stays stable all 5 cycles.
- Target answers rty twice, then ack, with MAX_RETRY = 3:
  - Two 1-cycle BACKOFF gaps with `m_cyc_o` low.
  - Status 00.
- Target answers rty 4 times with MAX_RETRY = 3:
  - Status 11 after the 4th rty.
  - `m_cyc_o` low in the following cycle.
- Silent target with TIMEOUT = 10:
  - `m_stb_o` high for exactly 10 cycles.
  - Status 10, `rsp_data_o` = 0.
- Boundary cases:
  - err and ack asserted together: status 01.
  - `rsp_ready_i` held low for 5 cycles: response held stable and `cmd_ready_o` stays 0.
  - `rst_i` asserted low mid-BUS: `m_cyc_o` drops without waiting for a clock edge and no response is emitted.
